// File: rtl/sdp_rdma_unpack_buf.sv
// rtl/sdp_rdma_unpack_buf.sv - splits buffered wide DMA read words into programmable narrow segments
module sdp_rdma_unpack_buf #(
    parameter int IW    = 512,
    parameter int OW    = 64,
    parameter int CW    = 1,
    parameter int DEPTH = 2
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic [3:0]       cfg_seg_num,
    input  logic             cfg_reverse,
    input  logic             inp_pvld,
    output logic             inp_prdy,
    input  logic [IW+CW-1:0] inp_data,
    output logic             out_pvld,
    input  logic             out_prdy,
    output logic [OW+CW-1:0] out_data,
    output logic             out_last,
    output logic             idle
);

    localparam int RATIO = IW / OW;
    localparam int SW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [IW+CW-1:0] mem [DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [3:0]       seg_cnt;
    logic             push;
    logic             pop;
    logic             last;
    logic [IW-1:0]    head_data;
    logic [CW-1:0]    head_ctrl;
    logic [OW-1:0]    segs [RATIO];
    logic [SW-1:0]    seg_sel;

    // Ready is a function of occupancy only, so out_prdy never reaches inp_prdy.
    assign inp_prdy = (count != 2'(DEPTH));
    assign out_pvld = (count != 2'd0);
    assign idle     = (count == 2'd0);
    assign push     = inp_pvld & inp_prdy;
    assign last     = out_pvld & (seg_cnt == cfg_seg_num);
    assign pop      = last & out_prdy;
    assign out_last = last;

    assign {head_ctrl, head_data} = mem[rd_ptr];

    always_comb begin
        for (int k = 0; k < RATIO; k++) begin
            segs[k] = head_data[k*OW +: OW];
        end
    end

    assign seg_sel  = cfg_reverse ? SW'(cfg_seg_num - seg_cnt) : SW'(seg_cnt);
    // Control rides only on the closing segment so downstream sees it once per word.
    assign out_data = {last ? head_ctrl : {CW{1'b0}}, segs[seg_sel]};

    always_ff @(posedge nvdla_core_clk) begin
        if (push) begin
            mem[wr_ptr] <= inp_data;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            count   <= 2'd0;
            seg_cnt <= 4'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (DEPTH == 1) ? 1'b0 : ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= (DEPTH == 1) ? 1'b0 : ~rd_ptr;
            end
            if (out_pvld && out_prdy) begin
                seg_cnt <= last ? 4'd0 : seg_cnt + 4'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sdp_rdma_unpack_buf.sv
// tb/tb_sdp_rdma_unpack_buf.sv - self-checking bench for sdp_rdma_unpack_buf
module tb_sdp_rdma_unpack_buf;

    localparam int IW = 512;
    localparam int OW = 64;
    localparam int CW = 1;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [3:0]        cfg_seg_num = 4'd0;
    logic              cfg_reverse = 1'b0;
    logic              inp_pvld = 1'b0;
    logic [IW+CW-1:0]  inp_data = '0;
    logic              out_prdy = 1'b0;
    logic              inp_prdy, out_pvld, out_last, idle;
    logic [OW+CW-1:0]  out_data;
    logic              inp_prdy1, out_pvld1, out_last1, idle1;
    logic [OW+CW-1:0]  out_data1;

    always #5 clk = ~clk;

    sdp_rdma_unpack_buf #(.IW(IW), .OW(OW), .CW(CW), .DEPTH(2)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rstn),
        .cfg_seg_num    (cfg_seg_num),
        .cfg_reverse    (cfg_reverse),
        .inp_pvld       (inp_pvld),
        .inp_prdy       (inp_prdy),
        .inp_data       (inp_data),
        .out_pvld       (out_pvld),
        .out_prdy       (out_prdy),
        .out_data       (out_data),
        .out_last       (out_last),
        .idle           (idle)
    );

    sdp_rdma_unpack_buf #(.IW(IW), .OW(OW), .CW(CW), .DEPTH(1)) dut1 (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rstn),
        .cfg_seg_num    (cfg_seg_num),
        .cfg_reverse    (cfg_reverse),
        .inp_pvld       (inp_pvld),
        .inp_prdy       (inp_prdy1),
        .inp_data       (inp_data),
        .out_pvld       (out_pvld1),
        .out_prdy       (out_prdy),
        .out_data       (out_data1),
        .out_last       (out_last1),
        .idle           (idle1)
    );

    typedef struct {
        logic [63:0] d;
        logic        c;
        logic        l;
    } beat_t;

    typedef struct {
        logic [3:0] seg_num;
        logic       rev;
        int         beats;
        int         first;
        int         step;
    } vec_t;

    int    n_cmp = 0;
    int    n_err = 0;
    int    n_beats = 0;
    int    pend = 0;
    beat_t sb[$];
    logic [3:0] p_seg = 4'd0;
    logic       p_rev = 1'b0;
    logic       p_idle = 1'b1;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkd(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [IW+CW-1:0] ramp(input int base);
        logic [IW+CW-1:0] w;
        w = '0;
        w[IW] = 1'b1;
        for (int k = 0; k < 8; k++) w[k*64 +: 64] = 64'(base + k);
        return w;
    endfunction

    function automatic logic [IW+CW-1:0] rnd_word();
        logic [IW+CW-1:0] w;
        for (int k = 0; k < 16; k++) w[k*32 +: 32] = $urandom;
        w[IW] = 1'(($urandom % 2));
        return w;
    endfunction

    // Reference model: each accepted word expands into its expected beat list.
    always @(negedge clk) begin
        beat_t b;
        int    ix;
        if (!rstn) begin
            sb.delete();
            pend = 0;
        end else begin
            chk1("mon_inp_prdy", inp_prdy, pend != 2);
            chk1("mon_out_pvld", out_pvld, pend != 0);
            chk1("mon_idle", idle, pend == 0);
            if (!out_pvld) begin
                chk1("mon_last_idle", out_last, 1'b0);
            end else if (sb.size() == 0) begin
                chk1("mon_unexpected_beat", 1'b1, 1'b0);
            end else begin
                chkd("mon_seg", out_data[63:0], sb[0].d);
                chk1("mon_ctrl", out_data[64], sb[0].c);
                chk1("mon_last", out_last, sb[0].l);
                if (out_prdy) begin
                    if (sb[0].l) pend--;
                    void'(sb.pop_front());
                    n_beats++;
                end
            end
            if (inp_pvld && inp_prdy) begin
                for (int k = 0; k <= int'(cfg_seg_num); k++) begin
                    ix = cfg_reverse ? int'(cfg_seg_num) - k : k;
                    b.d = inp_data[ix*64 +: 64];
                    b.l = (k == int'(cfg_seg_num));
                    b.c = b.l ? inp_data[IW] : 1'b0;
                    sb.push_back(b);
                end
                pend++;
            end
        end
        assert (cfg_seg_num <= 4'd7) else $error("cfg_seg_num out of range");
        if (cfg_seg_num != p_seg || cfg_reverse != p_rev)
            assert (idle && p_idle) else $error("configuration changed while busy");
        p_seg  = cfg_seg_num;
        p_rev  = cfg_reverse;
        p_idle = idle;
    end

    task automatic drain();
        logic ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        inp_pvld = 1'b0;
        out_prdy = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (idle) begin
                ok = 1'b1;
                break;
            end
        end
        chk1("drain_timeout", ok, 1'b1);
    endtask

    vec_t             tbl[7];
    int               j;
    int               beats0;
    logic             acc;
    logic [OW+CW-1:0] snap;

    initial begin
        tbl[0] = '{4'd7, 1'b0, 8, 1, 1};
        tbl[1] = '{4'd3, 1'b1, 4, 4, -1};
        tbl[2] = '{4'd0, 1'b0, 1, 1, 0};
        tbl[3] = '{4'd0, 1'b1, 1, 1, 0};
        tbl[4] = '{4'd7, 1'b1, 8, 8, -1};
        tbl[5] = '{4'd5, 1'b0, 6, 1, 1};
        tbl[6] = '{4'd2, 1'b1, 3, 3, -1};

        repeat (2) @(negedge clk);
        chk1("rst_out_pvld", out_pvld, 1'b0);
        chk1("rst_out_last", out_last, 1'b0);
        chk1("rst_ctrl", out_data[64], 1'b0);
        chk1("rst_inp_prdy", inp_prdy, 1'b1);
        chk1("rst_idle", idle, 1'b1);
        chk1("rst_idle_d1", idle1, 1'b1);
        chk1("rst_inp_prdy_d1", inp_prdy1, 1'b1);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        for (int t = 0; t < 7; t++) begin
            @(posedge clk);
            #1;
            cfg_seg_num = tbl[t].seg_num;
            cfg_reverse = tbl[t].rev;
            out_prdy    = 1'b1;
            inp_data    = ramp(1);
            inp_pvld    = 1'b1;
            @(posedge clk);
            #1;
            inp_pvld = 1'b0;
            for (int i = 0; i < tbl[t].beats; i++) begin
                @(negedge clk);
                chk1("tbl_pvld", out_pvld, 1'b1);
                chkd("tbl_seg", out_data[63:0], 64'(tbl[t].first + i * tbl[t].step));
                chk1("tbl_last", out_last, i == tbl[t].beats - 1);
                chk1("tbl_ctrl", out_data[64], i == tbl[t].beats - 1);
                @(posedge clk);
            end
            @(negedge clk);
            chk1("tbl_idle_after", idle, 1'b1);
            chk1("tbl_pvld_after", out_pvld, 1'b0);
        end

        // Back-to-back single-segment words at full rate.
        @(posedge clk);
        #1;
        cfg_seg_num = 4'd0;
        cfg_reverse = 1'b0;
        for (int i = 0; i < 10; i++) begin
            inp_data = ramp(1000 + i);
            inp_pvld = 1'b1;
            @(negedge clk);
            chk1("tp_inp_prdy", inp_prdy, 1'b1);
            if (i > 0) begin
                chk1("tp_out_pvld", out_pvld, 1'b1);
                chkd("tp_seg", out_data[63:0], 64'(1000 + i - 1));
            end
            @(posedge clk);
            #1;
        end
        inp_pvld = 1'b0;
        @(negedge clk);
        chk1("tp_out_pvld_end", out_pvld, 1'b1);
        chkd("tp_seg_end", out_data[63:0], 64'd1009);
        @(negedge clk);
        chk1("tp_idle_end", idle, 1'b1);

        // Backpressure: buffer fills after two words, head segment holds.
        @(posedge clk);
        #1;
        cfg_seg_num = 4'd1;
        out_prdy    = 1'b0;
        j           = 0;
        inp_data    = ramp(2000);
        inp_pvld    = 1'b1;
        beats0      = n_beats;
        snap        = '0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            acc = inp_prdy;
            if (cyc == 1) snap = out_data;
            if (cyc >= 2) begin
                chk1("bp_inp_prdy", inp_prdy, 1'b0);
                chkd("bp_stable", out_data[63:0], snap[63:0]);
                chk1("bp_last", out_last, 1'b0);
            end
            @(posedge clk);
            #1;
            if (acc) begin
                j++;
                if (j < 3) inp_data = ramp(2000 + 100 * j);
                else inp_pvld = 1'b0;
            end
        end
        chkd("bp_accepts", 64'(j), 64'd2);
        out_prdy = 1'b1;
        for (int c = 0; c < 40 && j < 3; c++) begin
            @(negedge clk);
            acc = inp_prdy & inp_pvld;
            @(posedge clk);
            #1;
            if (acc) begin
                j++;
                inp_pvld = 1'b0;
            end
        end
        chkd("bp_all_accepted", 64'(j), 64'd3);
        drain();
        chkd("bp_beats", 64'(n_beats - beats0), 64'd6);

        // Single-entry buffer: one beat every other cycle.
        @(posedge clk);
        #1;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn        = 1'b1;
        cfg_seg_num = 4'd0;
        cfg_reverse = 1'b0;
        inp_data    = ramp(85);
        inp_pvld    = 1'b1;
        out_prdy    = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk1("d1_out_pvld", out_pvld1, c % 2 == 1);
            chk1("d1_inp_prdy", inp_prdy1, c % 2 == 0);
            if (c % 2 == 1) begin
                chkd("d1_seg", out_data1[63:0], 64'd85);
                chk1("d1_ctrl", out_data1[64], 1'b1);
                chk1("d1_last", out_last1, 1'b1);
            end
        end
        drain();

        // Reset during a partially emitted word.
        @(posedge clk);
        #1;
        cfg_seg_num = 4'd7;
        inp_data    = ramp(1);
        inp_pvld    = 1'b1;
        @(posedge clk);
        #1;
        inp_pvld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk1("mr_out_pvld", out_pvld, 1'b0);
        chk1("mr_idle", idle, 1'b1);
        chk1("mr_inp_prdy", inp_prdy, 1'b1);
        chk1("mr_last", out_last, 1'b0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        inp_data = ramp(500);
        inp_pvld = 1'b1;
        @(posedge clk);
        #1;
        inp_pvld = 1'b0;
        @(negedge clk);
        chk1("mr_new_pvld", out_pvld, 1'b1);
        chkd("mr_new_seg0", out_data[63:0], 64'd500);
        drain();

        // Randomized traffic checked by the reference model.
        for (int blk = 0; blk < 6; blk++) begin
            @(posedge clk);
            #1;
            cfg_seg_num = 4'($urandom_range(0, 7));
            cfg_reverse = 1'($urandom % 2);
            for (int c = 0; c < 250; c++) begin
                inp_pvld = (($urandom % 3) != 0);
                inp_data = rnd_word();
                out_prdy = (($urandom % 4) != 0);
                @(posedge clk);
                #1;
            end
            drain();
        end

        chk1("sb_empty", sb.size() == 0, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sdp_rdma_unpack_buf.md
Name: sdp_rdma_unpack_buf

Overview:
Parametrised successor to the SDP RDMA width-splitting stage. It accepts wide DMA read words (data plus control sideband) into a small input buffer. Each buffered word is emitted as a programmable number of narrow segments toward the SDP datapath. Added over the previous generation:
- configurable segment count per word (replaces the fixed 8-bit/16-bit ratio select)
- descending segment order
- a 1- or 2-entry input buffer for full throughput with no out_prdy-to-inp_prdy combinational path
- explicit last-segment and idle indications

Parameters:
- IW, 512, input data width in bits (excluding control).
- OW, 64, output segment width in bits.
- CW, 1, control sideband width; carried from input MSBs.
- RATIO, IW/OW, derived; must be a power of two, 1..16.
- DEPTH, 2, input buffer entries; legal values 1 or 2.

Ports:
- nvdla_core_clk  input  1  core clock.
- nvdla_core_rstn  input  1  asynchronous active-low reset.
- cfg_seg_num  input  4  segments per word minus 1; legal 0..RATIO-1.
- cfg_reverse  input  1  1 = emit the highest segment first.
- inp_pvld  input  1  input word valid.
- inp_prdy  output  1  input ready.
- inp_data  input  IW+CW  {ctrl[CW-1:0], data[IW-1:0]}.
- out_pvld  output  1  segment valid.
- out_prdy  input  1  segment ready.
- out_data  output  OW+CW  {ctrl_end, segment}.
- out_last  output  1  current segment is the last of its word.
- idle  output  1  buffer empty.

Behaviour:
- Clock and reset: reset nvdla_core_rstn, asynchronous, active-low; clock nvdla_core_clk.
- Reset state: count=0, seg_cnt=0, buffer pointers=0. Outputs out_pvld=0, out_last=0, out_data ctrl field=0, inp_prdy=1, idle=1. Buffer data storage is not reset.
- Buffer: FIFO of DEPTH entries, each IW+CW bits; count range 0..DEPTH.
- inp_prdy = (count != DEPTH). It depends only on registered state; out_prdy has no combinational path to it.
- Push: inp_pvld & inp_prdy writes the tail entry. The word is visible at the output the next cycle, so latency from input accept to first out_pvld is 1 cycle.
- out_pvld = (count != 0). The head entry is the active word.
- Segment index: idx = cfg_reverse ? (cfg_seg_num - seg_cnt) : seg_cnt. Segment = head_data[idx*OW +: OW].
- out_last = out_pvld & (seg_cnt == cfg_seg_num).
- out_data ctrl field = head_ctrl when out_last, else 0. Control appears exactly once per word.
- Output transfer (out_pvld & out_prdy):
  - not last: seg_cnt increments.
  - last: seg_cnt returns to 0 and the head entry is popped.
- Segments above cfg_seg_num are discarded and never emitted.
- Simultaneous push and pop: count is unchanged and pointers advance independently. With DEPTH=2 and cfg_seg_num=0 this sustains 1 word/cycle.
- DEPTH=1: inp_prdy drops while the single word drains, giving a 1-cycle bubble between words.
- Stall: while out_pvld & !out_prdy, out_data, out_last and seg_cnt hold stable.
- idle = (count == 0).
- cfg_seg_num and cfg_reverse may change only while idle=1. Any other change is a usage error; it is not checked in RTL, and the bench asserts against it.
- Out-of-range cfg_seg_num (> RATIO-1) is illegal; the bench asserts cfg_seg_num <= RATIO-1.
- Reset asserted mid-word: immediate return to the reset state; partially emitted words are lost.

Test Plan:
- Forward order: IW=512, OW=64, cfg_seg_num=7, cfg_reverse=0, one word with seg k=k+1 and ctrl=1, out_prdy=1 → 8 beats at cycles 1..8 with data 1..8; ctrl=1 and out_last only on beat 8; idle=1 at cycle 9.
- Reverse, partial: cfg_seg_num=3, cfg_reverse=1, same word → 4 beats with data 4,3,2,1; segments 5..8 never appear; ctrl/out_last on the 4th beat.
- Full throughput: DEPTH=2, cfg_seg_num=0, 10 back-to-back words, out_prdy=1 → 10 beats on 10 consecutive cycles; inp_prdy stays 1 throughout.
- Backpressure: cfg_seg_num=1, out_prdy=0 for 5 cycles with 3 words offered → inp_prdy=0 after 2 accepts; out_data stable; on release the beats arrive in order with no loss or duplication.
- DEPTH=1: cfg_seg_num=0, continuous input → one output beat every 2 cycles.
- Reset mid-word: assert rstn=0 after 3 of 8 beats → out_pvld=0 and idle=1 immediately. A new word after reset starts at segment 0.
